// File: rtl/uart_mem_arbiter_if.sv
// Request/ready bus shared by the three requesters and the memory side.
//   req    : request, held until ready
//   we     : write enable
//   addr   : byte address
//   width  : access width code (00 byte, 01 halfword, 10 word), passed through
//   wdata  : write data (pN_data_in / mem_data_out)
//   rdata  : read data  (pN_data_out / mem_data_in)
//   ready  : one-cycle completion pulse
// master drives the request, slave answers with rdata/ready.
interface uart_mem_arbiter_if #(
  parameter int unsigned M_WIDTH = 32
);
  logic               req;
  logic               we;
  logic [M_WIDTH-1:0] addr;
  logic [1:0]         width;
  logic [M_WIDTH-1:0] wdata;
  logic [M_WIDTH-1:0] rdata;
  logic               ready;

  modport master (output req, we, addr, width, wdata, input rdata, ready);
  modport slave  (input req, we, addr, width, wdata, output rdata, ready);
endinterface

// File: rtl/uart_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the CPU data port (p0),
// the UART TX DMA read port (p1) and the UART RX DMA write port (p2).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   p0, p1, p2 : requester buses (slave side)
//   mem        : downstream memory bus (master side)
//   grant      : current owner 0..2, 2'b11 when idle
// The winner's we/addr/width/wdata are captured at grant, so requesters may
// change or drop their request while the transaction is in flight.
module uart_mem_arbiter #(
  parameter int unsigned M_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  uart_mem_arbiter_if.slave   p0,
  uart_mem_arbiter_if.slave   p1,
  uart_mem_arbiter_if.slave   p2,
  uart_mem_arbiter_if.master  mem,
  output logic [1:0]          grant
);

  localparam int unsigned N_PORTS    = 3;
  localparam logic [1:0]  GRANT_NONE = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           last_q, last_d;
  logic [1:0]           grant_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [M_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]           mem_width_q, mem_width_d;
  logic [M_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [N_PORTS-1:0]   ready_q, ready_d;
  logic [M_WIDTH-1:0]   rdata_q [N_PORTS];
  logic [M_WIDTH-1:0]   rdata_d [N_PORTS];
  logic [3:0]           req_v;
  logic [1:0]           cand;
  logic [1:0]           win;

  // Rotate 0 -> 1 -> 2 -> 0
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Top slot is a constant zero so a 2-bit index never leaves the vector
  assign req_v = {1'b0, p2.req, p1.req, p0.req};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 2'd2;
      grant       <= GRANT_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_width_q <= 2'b00;
      mem_wdata_q <= '0;
      ready_q     <= '0;
      for (int i = 0; i < N_PORTS; i++) rdata_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant       <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_width_q <= mem_width_d;
      mem_wdata_q <= mem_wdata_d;
      ready_q     <= ready_d;
      for (int i = 0; i < N_PORTS; i++) rdata_q[i] <= rdata_d[i];
    end
  end

  // Next-state, winner selection and capture
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_width_d = mem_width_q;
    mem_wdata_d = mem_wdata_q;
    ready_d     = '0;
    for (int i = 0; i < N_PORTS; i++) rdata_d[i] = rdata_q[i];

    // First requester after the last served port wins
    cand = next_port(last_q);
    win  = GRANT_NONE;
    for (int i = 0; i < N_PORTS; i++) begin
      if (win == GRANT_NONE && req_v[cand]) win = cand;
      cand = next_port(cand);
    end

    unique case (state_q)
      IDLE: begin
        if (win != GRANT_NONE) begin
          grant_d   = win;
          mem_req_d = 1'b1;
          state_d   = BUSY;
          case (win)
            2'd0: begin
              mem_we_d = p0.we; mem_addr_d = p0.addr;
              mem_width_d = p0.width; mem_wdata_d = p0.wdata;
            end
            2'd1: begin
              mem_we_d = p1.we; mem_addr_d = p1.addr;
              mem_width_d = p1.width; mem_wdata_d = p1.wdata;
            end
            2'd2: begin
              mem_we_d = p2.we; mem_addr_d = p2.addr;
              mem_width_d = p2.width; mem_wdata_d = p2.wdata;
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (mem.ready) begin
          mem_req_d = 1'b0;
          last_d    = grant;
          state_d   = RESP;
          for (int i = 0; i < N_PORTS; i++) begin
            if (grant == 2'(i)) begin
              ready_d[i] = 1'b1;
              // Writes leave the port's last read value in place
              if (!mem_we_q) rdata_d[i] = mem.rdata;
            end
          end
        end
      end
      RESP: begin
        grant_d = GRANT_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.req   = mem_req_q;
  assign mem.we    = mem_we_q;
  assign mem.addr  = mem_addr_q;
  assign mem.width = mem_width_q;
  assign mem.wdata = mem_wdata_q;

  assign p0.ready = ready_q[0];
  assign p1.ready = ready_q[1];
  assign p2.ready = ready_q[2];
  assign p0.rdata = rdata_q[0];
  assign p1.rdata = rdata_q[1];
  assign p2.rdata = rdata_q[2];

endmodule
